// File: rtl/fibre_a_spike_buffer_if.sv
// Loader, TPPE fibre_a read port and bank-release handshake of the spike buffer.
// The buffer takes the slave side; the loader/TPPE side takes master.
interface fibre_a_spike_buffer_if #(
  parameter int TIMESTEPS  = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  load_valid;
  logic                  load_ready;
  logic [TIMESTEPS-1:0]  load_data;
  logic                  load_last;
  logic [ADDR_WIDTH-1:0] fibre_a_addr;
  logic                  fibre_a_read_en;
  logic [TIMESTEPS-1:0]  fibre_a_data;
  logic                  fibre_a_valid;
  logic                  read_release;
  logic                  read_bank_ready;
  logic [ADDR_WIDTH:0]   read_count;
  logic                  addr_err;

  modport master (
    output load_valid, load_data, load_last, fibre_a_addr, fibre_a_read_en, read_release,
    input  load_ready, fibre_a_data, fibre_a_valid, read_bank_ready, read_count, addr_err
  );

  modport slave (
    input  load_valid, load_data, load_last, fibre_a_addr, fibre_a_read_en, read_release,
    output load_ready, fibre_a_data, fibre_a_valid, read_bank_ready, read_count, addr_err
  );
endinterface

// File: rtl/fibre_a_spike_buffer.sv
// Double-buffered spike-fibre memory: one bank fills from the loader while the
// TPPE reads the other; banks swap under the read_release handshake.
module fibre_a_spike_buffer #(
  parameter int TIMESTEPS    = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  fibre_a_spike_buffer_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic {W_FILL, W_WAIT}   wstate_e;
  typedef enum logic {R_IDLE, R_ACTIVE} rstate_e;

  logic [TIMESTEPS-1:0] mem [2][DEPTH];

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic                  wsel_q, wsel_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [CW-1:0]         hold_count_q, hold_count_d;
  logic [CW-1:0]         rcount_q, rcount_d;
  logic                  pend_q, pend_d;
  logic                  addr_err_q, addr_err_d;

  logic                  vld_q [READ_LATENCY];
  logic [TIMESTEPS-1:0]  dat_q [READ_LATENCY];

  logic                  load_accept;
  logic                  bank_close;
  logic [CW-1:0]         close_count;
  logic                  release_eff;
  logic                  rd_active;
  logic                  rd_in_range;
  logic                  rd_issue;
  logic [TIMESTEPS-1:0]  rd_word;

  assign load_accept = bus.load_valid && (wstate_q == W_FILL);
  assign bank_close  = load_accept && (bus.load_last || (&wptr_q));
  assign close_count = {1'b0, wptr_q} + CW'(1);
  assign release_eff = bus.read_release && (rstate_q == R_ACTIVE);
  assign rd_active   = (rstate_q == R_ACTIVE);
  assign rd_in_range = ({1'b0, bus.fibre_a_addr} < rcount_q);
  assign rd_issue    = bus.fibre_a_read_en && rd_active;
  // Bank data is captured at the issue edge so in-flight reads survive a swap.
  assign rd_word     = (rd_issue && rd_in_range) ? mem[~wsel_q][bus.fibre_a_addr] : '0;

  // pend_q marks a bank closed on the same edge as a release: it becomes
  // readable one cycle later, guaranteeing the ready gap without stalling loads.
  always_comb begin
    wstate_d     = wstate_q;
    rstate_d     = rstate_q;
    wsel_d       = wsel_q;
    wptr_d       = wptr_q;
    hold_count_d = hold_count_q;
    rcount_d     = rcount_q;
    pend_d       = 1'b0;
    addr_err_d   = addr_err_q | (bus.fibre_a_read_en && !(rd_active && rd_in_range));

    if (release_eff) begin
      rstate_d = R_IDLE;
    end
    if (pend_q) begin
      rstate_d = R_ACTIVE;
      rcount_d = hold_count_q;
    end

    unique case (wstate_q)
      W_FILL: begin
        if (load_accept) begin
          wptr_d = wptr_q + ADDR_WIDTH'(1);
        end
        if (bank_close) begin
          hold_count_d = close_count;
          wptr_d       = '0;
          if ((rstate_q == R_IDLE) && !pend_q) begin
            wsel_d   = ~wsel_q;
            rstate_d = R_ACTIVE;
            rcount_d = close_count;
          end else if (release_eff) begin
            wsel_d = ~wsel_q;
            pend_d = 1'b1;
          end else begin
            wstate_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if ((rstate_q == R_IDLE) && !pend_q) begin
          wsel_d   = ~wsel_q;
          wstate_d = W_FILL;
          rstate_d = R_ACTIVE;
          rcount_d = hold_count_q;
        end
      end
      default: begin
        wstate_d = W_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q     <= W_FILL;
      rstate_q     <= R_IDLE;
      wsel_q       <= 1'b0;
      wptr_q       <= '0;
      hold_count_q <= '0;
      rcount_q     <= '0;
      pend_q       <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      wsel_q       <= wsel_d;
      wptr_q       <= wptr_d;
      hold_count_q <= hold_count_d;
      rcount_q     <= rcount_d;
      pend_q       <= pend_d;
      addr_err_q   <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && load_accept) begin
      mem[wsel_q][wptr_q] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_issue;
      dat_q[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign bus.load_ready      = (wstate_q == W_FILL);
  assign bus.read_bank_ready = rd_active;
  assign bus.read_count      = rd_active ? rcount_q : '0;
  assign bus.fibre_a_valid   = vld_q[READ_LATENCY-1];
  assign bus.fibre_a_data    = dat_q[READ_LATENCY-1];
  assign bus.addr_err        = addr_err_q;

endmodule

// File: doc/fibre_a_spike_buffer.md
# fibre_a_spike_buffer

Double-buffered spike-fibre memory that answers the TPPE's fibre_a read port. The upstream spike loader fills one bank with per-position TIMESTEPS-bit spike vectors while the TPPE reads the other bank through `fibre_a_addr`/`fibre_a_read_en`. Each accepted read is answered with `fibre_a_data`/`fibre_a_valid` after a fixed latency. Banks swap under a release handshake, so the next fibre loads while the current one is consumed.

## Interface
- TIMESTEPS, 8, spike vector width per position
- ADDR_WIDTH, 8, read/write address width; bank depth DEPTH = 2**ADDR_WIDTH
- READ_LATENCY, 2, cycles from accepted read to `fibre_a_valid`; legal range 1..4
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- load_valid  in  1  loader offers `load_data`
- load_ready  out  1  buffer accepts a load this cycle
- load_data  in  TIMESTEPS  spike vector for next sequential position
- load_last  in  1  qualifies `load_data` as the final entry of the fibre
- fibre_a_addr  in  ADDR_WIDTH  read address (position within fibre)
- fibre_a_read_en  in  1  read request
- fibre_a_data  out  TIMESTEPS  read data
- fibre_a_valid  out  1  one-cycle pulse per answered read
- read_release  in  1  consumer finished with current read bank
- read_bank_ready  out  1  a complete fibre is available for reads
- read_count  out  ADDR_WIDTH+1  entries in the read bank, 1..DEPTH
- addr_err  out  1  sticky: read out of range or read while not ready

## Operation
- Two banks of DEPTH x TIMESTEPS. Write bank pointer `wsel`; read bank is `~wsel` when `read_bank_ready`.
- Write FSM: FILL, WAIT.
  - FILL: `load_ready`=1. Each accept writes `load_data` at `wptr` and increments `wptr`.
  - Accept with `load_last`, or the accept at `wptr`=DEPTH-1 (implicit last), closes the bank with `count`=`wptr`+1.
  - On close, if the read side is IDLE: swap, `wptr`=0, and stay in FILL.
  - On close, if the read side is ACTIVE: go to WAIT.
  - WAIT: `load_ready`=0. On release, swap and return to FILL.
- Read FSM: IDLE, ACTIVE.
  - ACTIVE asserts `read_bank_ready` and holds `read_count`.
  - `read_release` while ACTIVE returns the FSM to IDLE. While IDLE, `read_release` is ignored.
- Reads: `fibre_a_read_en` while ACTIVE with `fibre_a_addr` < `read_count` returns the stored vector.
  - If `fibre_a_addr` >= `read_count`, data is 0, valid is still returned, and `addr_err` is set.
  - `fibre_a_read_en` while IDLE produces no valid and sets `addr_err`.
  - Back-to-back reads are accepted every cycle. Responses come back in order.
- Bank data is sampled at the issue edge, so in-flight reads return old-bank data after a release or swap.
- `addr_err` clears only on `rst`.

## Timing
- Reset values:
  - `load_ready`=1; all other outputs 0.
  - `wptr`=0, `wsel`=0, both FSMs in FILL/IDLE.
  - In-flight reads are discarded (no valid after reset). Memory contents are not cleared.
- Load accept: `load_valid && load_ready` at edge N writes memory at N.
- Close at edge N with read IDLE:
  - `read_bank_ready`=1 and `read_count` valid from N+1.
  - `load_ready` stays 1, so the new fill may start at N+1.
- Close at N with read ACTIVE: `load_ready`=0 from N+1.
- Release at edge M (ACTIVE): `read_bank_ready`=0 at M+1.
  - If the write side is in WAIT: swap at M+1, `read_bank_ready`=1 and `load_ready`=1 at M+2.
  - The ready gap is always at least one cycle.
- Simultaneous close and release at the same edge: release is processed first, then the close sees IDLE. Result: `read_bank_ready` low at N+1, high at N+2 with the new bank, and no WAIT.
- Read issued at edge R: `fibre_a_valid`=1 and `fibre_a_data` driven during cycle R+READ_LATENCY only. `fibre_a_data` is 0 when not valid.
- Reset asserted mid-fill or mid-read: everything returns to reset values at the next edge. The partial bank is discarded.

## Test plan
- Load 5 vectors 0x01..0x05 with `load_last` on the fifth, READ_LATENCY=2 -> `read_bank_ready`=1 and `read_count`=5 one cycle after the fifth accept. Reads addr 0..4 back-to-back -> valid pulses on 5 consecutive cycles, 2 cycles after each issue, data 0x01..0x05.
- Fibre A (3 entries) readable; load fibre B (2 entries, 0xAA, 0xBB) -> `load_ready`=0 after B's last. Assert `read_release` -> `read_bank_ready` low 1 cycle, then high with `read_count`=2, addr 1 returns 0xBB, `load_ready`=1.
- `read_count`=3, read addr 7 -> valid with data 0x00 and `addr_err`=1 stays set. Read while `read_bank_ready`=0 -> no valid.
- Load DEPTH entries without `load_last` -> implicit close, `read_count`=DEPTH, addr DEPTH-1 returns the last vector.
- Issue read at addr 2, assert `read_release` the next cycle -> the response still returns the old-bank value. Assert `rst` during a 3-entry fill -> `load_ready`=1, `read_bank_ready`=0, no stray `fibre_a_valid`.
- Close and `read_release` on the same edge with the read side ACTIVE -> `read_bank_ready` low 1 cycle then high with the new count, `load_ready` never deasserts.
